// File: rtl/memwrite_streamer_pkg.sv
// Shared types and constants for the data-memory write streamer.
// Optional feature macro: MEMWRITE_STREAM_CHECKSUM_EN (adds an XOR checksum byte to each frame).
package memwrite_streamer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef MEMWRITE_STREAM_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 8;
`else
    localparam int unsigned FRAME_LEN = 7;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } event_t;

    // Byte idx of the serial frame built from one buffered write event.
    function automatic logic [7:0] frame_byte(input event_t ev, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = ev.addr[15:8];
            3'd2:    b = ev.addr[7:0];
            3'd3:    b = ev.data[31:24];
            3'd4:    b = ev.data[23:16];
            3'd5:    b = ev.data[15:8];
            3'd6:    b = ev.data[7:0];
`ifdef MEMWRITE_STREAM_CHECKSUM_EN
            // Checksum covers every byte except the sync byte.
            3'd7:    b = ev.addr[15:8] ^ ev.addr[7:0] ^ ev.data[31:24] ^ ev.data[23:16]
                         ^ ev.data[15:8] ^ ev.data[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty/level; a push on a full FIFO is accepted only when a pop
// happens on the same edge. Synchronous active-high reset.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(Depth):0]     level
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_eff;
    logic             pop_eff;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign rdata = mem_q[rptr_q];

    assign pop_eff  = pop && !empty;
    // When full, the slot under wptr is the head being popped, so overwriting it is safe.
    assign push_eff = push && (!full || pop_eff);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_eff) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + PtrW'(1);
        end
        if (pop_eff) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push_eff && !pop_eff) begin
            count_d = count_q + CntW'(1);
        end else if (!push_eff && pop_eff) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/memwrite_streamer.sv
// Snoops data-memory writes and re-emits each as a byte-serial frame on a valid/ready stream.
// Optional feature macro: MEMWRITE_STREAM_CHECKSUM_EN (8-byte frame with trailing XOR byte).
module memwrite_streamer
    import memwrite_streamer_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DM_ADDRESS-1:0]         wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned EvW      = $bits(event_t);
    localparam logic [2:0]  LAST_IDX = 3'(FRAME_LEN - 1);

    state_e           state_q, state_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    event_t           frame_q, frame_d;
    logic             overflow_q, overflow_d;
    event_t           ev_in;
    logic [EvW-1:0]   fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    always_comb begin
        ev_in.addr = 16'(wr_addr);
        ev_in.data = 32'(wr_data);
    end

    sync_fifo #(
        .Width (EvW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .wdata (ev_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Frame sequencer: loads the FIFO head and walks its bytes, chaining frames without a gap.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    frame_d    = event_t'(fifo_rdata);
                    byte_idx_d = 3'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (byte_idx_q != LAST_IDX) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        frame_d    = event_t'(fifo_rdata);
                        byte_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky drop flag: a write that the FIFO could not take.
    always_comb begin
        overflow_d = overflow_q | (wr_en & fifo_full & ~pop);
    end

    // Sequencer and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_idx_q <= 3'd0;
            frame_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            frame_q    <= frame_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs are pure functions of registered state, so they hold while stalled.
    always_comb begin
        out_valid = (state_q == SEND);
        out_data  = out_valid ? frame_byte(frame_q, byte_idx_q) : 8'h00;
        overflow  = overflow_q;
    end

endmodule
